// File: rtl/ultrasonic_pkg.sv
// Shared encodings, counter width and default timing for the ultrasonic echo emulator
// and the ranging controller that talks to it.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRIG_HI = 3'd1,
        ST_BURST   = 3'd2,
        ST_ECHO    = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    localparam int CNT_W = 22;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam int unsigned DEF_CLK_HZ       = 50_000_000;
    localparam int unsigned DEF_TRIG_MIN_CYC = 500;
    localparam int unsigned DEF_BURST_CYC    = 10_000;
    localparam int unsigned DEF_CYC_PER_CM   = 2_900;
    localparam int unsigned DEF_MAX_CM       = 400;
    localparam int unsigned DEF_TIMEOUT_CYC  = 1_900_000;
    localparam int unsigned DEF_HOLDOFF_CYC  = 500_000;

    // Out-of-range distances (0 or beyond max_cm) report as no-target.
    function automatic cnt_t echo_width(input logic [8:0]  cm,
                                        input int unsigned cyc_per_cm,
                                        input int unsigned max_cm,
                                        input int unsigned timeout_cyc);
        logic [31:0] cm_w;
        cnt_t        width;
        cm_w = {23'd0, cm};
        if (cm_w >= 32'd1 && cm_w <= max_cm)
            width = cnt_t'(cm_w * cyc_per_cm);
        else
            width = cnt_t'(timeout_cyc);
        return width;
    endfunction

endpackage

// File: rtl/ultrasonic_echo_emulator_sync_2ff.sv
// 1-bit two-flop synchronizer with asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ultrasonic_echo_emulator.sv
// Emulates an HC-SR04 style ultrasonic ranger: trig pulse in, distance-encoded echo out.
//   state      | meaning
//   IDLE       | waiting for a qualified trig rising edge
//   TRIG_HI    | counting trig high time (saturating down-counter)
//   BURST      | emulated 40 kHz burst delay
//   ECHO       | echo high for the distance-derived width
//   HOLDOFF    | dead time before re-arm, trig ignored
module ultrasonic_echo_emulator
    import ultrasonic_pkg::*;
#(
    parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
    parameter int unsigned TRIG_MIN_CYC = DEF_TRIG_MIN_CYC,
    parameter int unsigned BURST_CYC    = DEF_BURST_CYC,
    parameter int unsigned CYC_PER_CM   = DEF_CYC_PER_CM,
    parameter int unsigned MAX_CM       = DEF_MAX_CM,
    parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter int unsigned HOLDOFF_CYC  = DEF_HOLDOFF_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trig,
    input  logic [8:0] distance_cm,
    output logic       echo,
    output logic       busy,
    output logic       trig_err,
    output logic       meas_done
);

    localparam cnt_t ONE = cnt_t'(1);

    if (CLK_HZ == 0 || TRIG_MIN_CYC == 0 || BURST_CYC == 0 || CYC_PER_CM == 0 ||
        TIMEOUT_CYC == 0 || HOLDOFF_CYC == 0) begin : g_param_check
        $error("ultrasonic_echo_emulator: timing parameters must be non-zero");
    end

    state_t     state, state_next;
    cnt_t       cnt, cnt_next;
    logic [8:0] dist_lat;
    logic       latch_en;
    logic       trig_s, trig_prev;
    logic [1:0] prime;
    logic       armed;

    sync_2ff u_sync_trig (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (trig),
        .q     (trig_s)
    );

    // armed only sets once the synchronizer carries real post-reset samples, so a trig
    // held high across reset must be seen low before it can start a measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            dist_lat  <= '0;
            trig_prev <= 1'b0;
            prime     <= 2'b00;
            armed     <= 1'b0;
            echo      <= 1'b0;
            meas_done <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            trig_prev <= trig_s;
            prime     <= {prime[0], 1'b1};
            armed     <= armed | (prime[1] & ~trig_s);
            if (latch_en)
                dist_lat <= distance_cm;
            echo      <= (state_next == ST_ECHO);
            meas_done <= (state == ST_ECHO) && (state_next == ST_HOLDOFF);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        latch_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_next = '0;
                if (trig_s && !trig_prev && armed) begin
                    state_next = ST_TRIG_HI;
                    cnt_next   = cnt_t'(TRIG_MIN_CYC - 1);
                end
            end
            ST_TRIG_HI: begin
                if (trig_s) begin
                    cnt_next = (cnt == '0) ? '0 : cnt - ONE;
                end else if (cnt == '0) begin
                    state_next = ST_BURST;
                    cnt_next   = cnt_t'(BURST_CYC - 1);
                    latch_en   = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            ST_BURST: begin
                if (cnt == '0) begin
                    state_next = ST_ECHO;
                    cnt_next   = echo_width(dist_lat, CYC_PER_CM, MAX_CM, TIMEOUT_CYC) - ONE;
                end else begin
                    cnt_next = cnt - ONE;
                end
            end
            ST_ECHO: begin
                if (cnt == '0) begin
                    state_next = ST_HOLDOFF;
                    cnt_next   = cnt_t'(HOLDOFF_CYC - 1);
                end else begin
                    cnt_next = cnt - ONE;
                end
            end
            ST_HOLDOFF: begin
                if (cnt == '0) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        trig_err = (state == ST_TRIG_HI) && !trig_s && (cnt != '0);
    end

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Scoreboard bench: expected echo widths queued at trigger time, checked when echo falls.
module tb_ultrasonic_echo_emulator;

    localparam int unsigned TRIG_MIN_CYC = 10;
    localparam int unsigned BURST_CYC    = 20;
    localparam int unsigned CYC_PER_CM   = 5;
    localparam int unsigned MAX_CM       = 400;
    localparam int unsigned TIMEOUT_CYC  = 3000;
    localparam int unsigned HOLDOFF_CYC  = 50;
    localparam int          LIMIT        = 5000;
    // trig drop -> 2 sync flops -> TRIG_HI decides -> BURST_CYC -> echo flop, seen on negedge
    localparam int          LATENCY      = BURST_CYC + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trig;
    logic [8:0] distance_cm;
    logic       echo, busy, trig_err, meas_done;

    int total = 0;
    int bad   = 0;

    int   exp_q[$];
    int   ew       = 0;
    int   rise_cnt = 0;
    int   md_cnt   = 0;
    int   err_cnt  = 0;
    logic echo_d   = 1'b0;
    logic skip_next = 1'b0;

    ultrasonic_echo_emulator #(
        .CLK_HZ       (50_000_000),
        .TRIG_MIN_CYC (TRIG_MIN_CYC),
        .BURST_CYC    (BURST_CYC),
        .CYC_PER_CM   (CYC_PER_CM),
        .MAX_CM       (MAX_CM),
        .TIMEOUT_CYC  (TIMEOUT_CYC),
        .HOLDOFF_CYC  (HOLDOFF_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig        (trig),
        .distance_cm (distance_cm),
        .echo        (echo),
        .busy        (busy),
        .trig_err    (trig_err),
        .meas_done   (meas_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_width(input int cm);
        if (cm >= 1 && cm <= int'(MAX_CM))
            return cm * int'(CYC_PER_CM);
        return int'(TIMEOUT_CYC);
    endfunction

    always @(negedge clk) begin
        if (meas_done) md_cnt++;
        if (trig_err)  err_cnt++;
        if (echo) begin
            if (!echo_d) begin
                ew = 1;
                rise_cnt++;
            end else begin
                ew++;
            end
        end else if (echo_d) begin
            if (skip_next) begin
                skip_next = 1'b0;
            end else if (exp_q.size() == 0) begin
                chk("sb_unexpected_echo", ew, -1);
            end else begin
                chk("echo_width", ew, exp_q.pop_front());
                chk("meas_done_at_fall", int'(meas_done), 1);
            end
        end
        echo_d = echo;
    end

    task automatic drive_trig(input int n);
        @(negedge clk);
        trig = 1'b1;
        repeat (n) @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic wait_echo(input logic level, output int t);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (echo != level && t < LIMIT);
    endtask

    // One accepted measurement; disturb re-triggers and changes distance mid-echo.
    task automatic measure(input int cm, input int n, input bit disturb);
        int t, md0, er0, r0;
        distance_cm = 9'(cm);
        md0 = md_cnt;
        er0 = err_cnt;
        r0  = rise_cnt;
        exp_q.push_back(model_width(cm));
        drive_trig(n);
        wait_echo(1'b1, t);
        chk("burst_latency", t, LATENCY);
        if (disturb) begin
            repeat (50) @(negedge clk);
            distance_cm = 9'd7;
            drive_trig(12);
        end
        wait_echo(1'b0, t);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < LIMIT);
        chk("holdoff_len", t, int'(HOLDOFF_CYC));
        repeat (40) @(negedge clk);
        chk("meas_done_pulses", md_cnt - md0, 1);
        chk("trig_err_pulses", err_cnt - er0, 0);
        chk("echo_rises", rise_cnt - r0, 1);
        chk("idle_after", int'(busy), 0);
    endtask

    task automatic reject(input int n);
        int t, er0, r0;
        er0 = err_cnt;
        r0  = rise_cnt;
        drive_trig(n);
        t = 0;
        while (!trig_err && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("trig_err_seen", int'(trig_err), 1);
        @(negedge clk);
        chk("busy_after_reject", int'(busy), 0);
        repeat (BURST_CYC + 10) @(negedge clk);
        chk("reject_err_pulses", err_cnt - er0, 1);
        chk("reject_no_echo", rise_cnt - r0, 0);
    endtask

    initial begin
        int t, r0;
        rst_n = 1'b0;
        trig = 1'b0;
        distance_cm = 9'd0;
        repeat (3) @(negedge clk);
        chk("rst_echo", int'(echo), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_trig_err", int'(trig_err), 0);
        chk("rst_meas_done", int'(meas_done), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        measure(100, 12, 1'b0);
        reject(5);
        reject(9);
        measure(1, 10, 1'b0);
        measure(0, 12, 1'b0);
        measure(450, 12, 1'b0);
        measure(400, 12, 1'b0);
        measure(401, 11, 1'b0);
        measure(100, 12, 1'b1);

        // reset mid-echo with trig held high
        distance_cm = 9'd100;
        exp_q.push_back(model_width(100));
        drive_trig(12);
        wait_echo(1'b1, t);
        repeat (100) @(negedge clk);
        trig = 1'b1;
        void'(exp_q.pop_back());
        skip_next = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_echo", int'(echo), 0);
        chk("rst_async_busy", int'(busy), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        r0 = rise_cnt;
        repeat (100) @(negedge clk);
        chk("held_trig_busy", int'(busy), 0);
        chk("held_trig_no_echo", rise_cnt - r0, 0);
        trig = 1'b0;
        repeat (5) @(negedge clk);
        measure(100, 12, 1'b0);

        chk("sb_leftover", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
